setbit_iter: RTL and testbench

Sequential set-bit enumerator, the inverse of the population-count and one-hot checks. It accepts a WIDTH-bit vector and emits each set bit, LSB first, one per output handshake as a one-hot word plus its binary index. After the last bit it reports the total number of bits emitted, which must equal the vector's ones count. It sits downstream of any producer of bit masks, such as request vectors or valid masks, that need serialising.

---
 rtl/setbit_iter_if.sv | 29 ++
 rtl/setbit_iter.sv | 149 ++++++++++++++
 tb/tb_setbit_iter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/setbit_iter_if.sv
// Handshake bundle for setbit_iter: vector input channel, per-bit output channel, and completion report.
// slave is the enumerator's view; master is the view of whoever drives it and consumes its beats.
interface setbit_iter_if #(
    parameter int WIDTH = 16
);
    localparam int IDXW = $clog2(WIDTH);
    localparam int CNTW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_onehot;
    logic [IDXW-1:0]  out_index;
    logic             out_last;
    logic             done;
    logic [CNTW-1:0]  done_count;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_onehot, out_index, out_last, done, done_count
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_onehot, out_index, out_last, done, done_count
    );
endinterface

// File: rtl/setbit_iter.sv
// Serialises the set bits of a WIDTH-bit vector, LSB first, then reports how many beats were emitted.
// Optional checking logic is enabled by defining SETBIT_ITER_ASSERT_EN.
module setbit_iter #(
    parameter  int WIDTH = 16,
    localparam int IDXW  = $clog2(WIDTH),
    localparam int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    setbit_iter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [CNTW-1:0]  cnt_reg, cnt_next;
    logic [CNTW-1:0]  done_count_reg, done_count_next;

    logic [WIDTH-1:0] low_bit;
    logic [IDXW-1:0]  low_index;
    logic             is_last;
    logic             accept;
    logic             fire;

    // Bit b of an index is set for every position whose binary index has bit b set.
    function automatic logic [WIDTH-1:0] idx_mask(input int b);
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = ((i >> b) & 1) == 1;
        end
        return m;
    endfunction

    assign low_bit = rem_reg & (~rem_reg + WIDTH'(1));
    assign is_last = (rem_reg & (rem_reg - WIDTH'(1))) == '0;
    assign accept  = (state_reg == IDLE) && bus.in_valid;
    assign fire    = (state_reg == RUN) && bus.out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < IDXW; gi++) begin : g_index
            localparam logic [WIDTH-1:0] MASK = idx_mask(gi);
            assign low_index[gi] = |(low_bit & MASK);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rem_reg        <= '0;
            cnt_reg        <= '0;
            done_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            rem_reg        <= rem_next;
            cnt_reg        <= cnt_next;
            done_count_reg <= done_count_next;
        end
    end

    // done_count is loaded on entry to FIN so the value is already visible during the done pulse.
    always_comb begin
        state_next      = state_reg;
        rem_next        = rem_reg;
        cnt_next        = cnt_reg;
        done_count_next = done_count_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    rem_next = bus.in_data;
                    cnt_next = '0;
                    if (bus.in_data == '0) begin
                        state_next      = FIN;
                        done_count_next = '0;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (fire) begin
                    rem_next = rem_reg & ~low_bit;
                    cnt_next = cnt_reg + CNTW'(1);
                    if (is_last) begin
                        state_next      = FIN;
                        done_count_next = cnt_reg + CNTW'(1);
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_onehot = '0;
        bus.out_index  = '0;
        bus.out_last   = 1'b0;
        bus.done       = 1'b0;
        case (state_reg)
            IDLE: bus.in_ready = 1'b1;
            RUN: begin
                bus.out_valid  = 1'b1;
                bus.out_onehot = low_bit;
                bus.out_index  = low_index;
                bus.out_last   = is_last;
            end
            FIN:     bus.done = 1'b1;
            default: bus.in_ready = 1'b0;
        endcase
    end

    assign bus.done_count = done_count_reg;

`ifdef SETBIT_ITER_ASSERT_EN
    logic [WIDTH-1:0] shadow_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= '0;
        end else if (accept) begin
            shadow_reg <= bus.in_data;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                assert ($onehot(bus.out_onehot));
                assert (bus.out_onehot == (WIDTH'(1) << bus.out_index));
                assert (!$isunknown(rem_reg));
            end
            if (bus.done) begin
                assert (bus.done_count == CNTW'($countones(shadow_reg)));
            end
        end
    end
`else
    // Functional build: no shadow capture and no runtime checks.
`endif

endmodule

// File: tb/tb_setbit_iter.sv
// Directed bench for setbit_iter at WIDTH=8: expected beats and done counts are queued at acceptance
// and popped as the DUT presents them; latency and in_ready timing are checked alongside.
module tb_setbit_iter;

    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] oh;
        logic [2:0] idx;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    setbit_iter_if #(.WIDTH(WIDTH)) bus ();

    setbit_iter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    beat_t bq[$];
    int    dq[$];
    int    lq[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    accept_cyc = 0;
    int    stall_cnt  = 0;
    bit    exp_ready  = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive the inputs for the new cycle just after the edge, then check what the DUT shows.
    task automatic tick(input logic v, input logic [7:0] d, input logic rdy);
        beat_t b;
        int    k;
        int    hi;
        bit    next_ready;
        @(posedge clk);
        #1;
        cyc++;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = rdy;
        #1;
        next_ready = exp_ready;
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        if (bus.done) begin
            chk("done_expected", dq.size() > 0, 1);
            if (dq.size() > 0) begin
                chk("done_count", {28'd0, bus.done_count}, dq.pop_front());
                chk("done_latency", cyc - accept_cyc, lq.pop_front() + stall_cnt);
                chk("beats_drained", bq.size(), 0);
            end
            next_ready = 1'b1;
        end
        if (bus.out_valid) begin
            chk("beat_expected", bq.size() > 0, 1);
            if (bq.size() > 0) begin
                b = bq[0];
                chk("out_onehot", {24'd0, bus.out_onehot}, {24'd0, b.oh});
                chk("out_index", {29'd0, bus.out_index}, {29'd0, b.idx});
                chk("out_last", {31'd0, bus.out_last}, {31'd0, b.last});
                if (rdy) void'(bq.pop_front());
                else stall_cnt++;
            end
        end else begin
            chk("idle_outputs", {20'd0, bus.out_onehot, bus.out_index, bus.out_last}, 0);
        end
        if (bus.in_ready && v) begin
            k  = 0;
            hi = -1;
            for (int i = 0; i < WIDTH; i++) if (d[i]) hi = i;
            for (int i = 0; i < WIDTH; i++) begin
                if (d[i]) begin
                    b.oh   = 8'(1 << i);
                    b.idx  = 3'(i);
                    b.last = (i == hi);
                    bq.push_back(b);
                    k++;
                end
            end
            dq.push_back(k);
            lq.push_back(k + 1);
            accept_cyc = cyc;
            stall_cnt  = 0;
            next_ready = 1'b0;
        end
        exp_ready = next_ready;
    endtask

    task automatic drain(input bit toggle);
        for (int i = 0; i < 40 && dq.size() > 0; i++) begin
            tick(1'b0, 8'h00, toggle ? ~i[0] : 1'b1);
        end
        chk("drain_bound", dq.size(), 0);
        tick(1'b0, 8'h00, 1'b1);
    endtask

    task automatic run_vec(input logic [7:0] d, input bit toggle);
        tick(1'b1, d, 1'b1);
        drain(toggle);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
        chk("rst_outputs", {19'd0, bus.out_valid, bus.out_onehot, bus.out_index, bus.out_last}, 0);
        chk("rst_done", {27'd0, bus.done, bus.done_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(8'ha5, 1'b0);
        run_vec(8'h00, 1'b0);
        run_vec(8'hff, 1'b1);
        run_vec(8'h80, 1'b0);

        // Reset mid-enumeration: two beats taken, then the rest must vanish without a done pulse.
        tick(1'b1, 8'h0f, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clear", {18'd0, bus.out_valid, bus.out_onehot, bus.out_index, bus.out_last, bus.done}, 0);
        chk("async_in_ready", {31'd0, bus.in_ready}, 1);
        bq.delete();
        dq.delete();
        lq.delete();
        exp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_no_done", {27'd0, bus.done, bus.done_count}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(8'h30, 1'b0);

        // in_valid held high with changing data while busy: only the IDLE-cycle value is taken next.
        tick(1'b1, 8'h81, 1'b1);
        tick(1'b1, 8'hff, 1'b1);
        tick(1'b1, 8'hee, 1'b1);
        tick(1'b1, 8'h11, 1'b1);
        tick(1'b1, 8'h5a, 1'b1);
        drain(1'b0);

        chk("final_beats_empty", bq.size(), 0);
        chk("final_done_empty", dq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
